// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel stage: RAM line buffers, 3-cycle pipeline, saturated |dx|+|dy| plus edge flag.
// Define SOBEL_DIRECTION_EN to add the out_dir gradient-direction output.
module sobel_stream_filter #(
    parameter int WORD_SIZE = 8,
    parameter int MAX_WIDTH = 1024,
    parameter int COL_W     = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [COL_W-1:0]     frame_width,
    input  logic [WORD_SIZE-1:0] threshold,
    input  logic                 in_valid,
    input  logic                 in_sof,
    input  logic                 in_eol,
    input  logic [WORD_SIZE-1:0] in_data,
    output logic                 out_valid,
    output logic                 out_sof,
    output logic                 out_eol,
    output logic [WORD_SIZE-1:0] out_mag,
    output logic                 out_edge,
`ifdef SOBEL_DIRECTION_EN
    output logic [1:0]           out_dir,
`endif
    output logic                 len_err,
    output logic                 cfg_err
);

    localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam int DW = WORD_SIZE + 3;
    localparam int SW = WORD_SIZE + 4;
    localparam logic [SW-1:0] SAT = SW'((1 << WORD_SIZE) - 1);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t               r_state;
    logic [15:0]          r_row;
    logic [COL_W-1:0]     r_col;
    logic [COL_W-1:0]     r_width;

    logic [WORD_SIZE-1:0] r_lb0 [MAX_WIDTH];
    logic [WORD_SIZE-1:0] r_lb1 [MAX_WIDTH];
    logic [WORD_SIZE-1:0] r_win [3][3];

    logic                 r_v1, r_sof1, r_eol1, r_bord1;
    logic                 r_v2, r_sof2, r_eol2, r_bord2;
    logic [DW-1:0]        r_adx, r_ady;

    logic                 w_width_ok, w_acc, w_last;
    logic [COL_W-1:0]     w_col;
    logic [15:0]          w_row;
    logic [AW-1:0]        w_addr;
    logic [WORD_SIZE-1:0] w_lb0, w_lb1;
    logic [DW-1:0]        w_left, w_right, w_top, w_bot;
    logic signed [DW-1:0] w_dx, w_dy;
    logic [SW-1:0]        w_sum;
    logic [WORD_SIZE-1:0] w_sat;

    always_comb begin
        w_width_ok = (frame_width >= COL_W'(3)) && (frame_width <= COL_W'(MAX_WIDTH));
        w_acc      = in_valid && ((in_sof && w_width_ok) || (!in_sof && r_state == S_ACTIVE));
        w_last     = (r_col == r_width - COL_W'(1));
        w_col      = in_sof ? '0 : r_col;
        w_row      = in_sof ? '0 : r_row;
        w_addr     = w_col[AW-1:0];
        w_lb0      = r_lb0[w_addr];
        w_lb1      = r_lb1[w_addr];
    end

    // Frame/row tracking; sof takes priority over eol for the counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_row   <= '0;
            r_col   <= '0;
            r_width <= '0;
            len_err <= 1'b0;
            cfg_err <= 1'b0;
        end else if (in_valid) begin
            if (in_sof) begin
                if (w_width_ok) begin
                    r_state <= S_ACTIVE;
                    r_width <= frame_width;
                    r_row   <= '0;
                    r_col   <= COL_W'(1);
                    cfg_err <= 1'b0;
                    len_err <= 1'b0;
                end else begin
                    r_state <= S_IDLE;
                    cfg_err <= 1'b1;
                end
            end else if (r_state == S_ACTIVE) begin
                if (in_eol || w_last) begin
                    r_col <= '0;
                    if (r_row != '1)
                        r_row <= r_row + 16'd1;
                    if (in_eol != w_last)
                        len_err <= 1'b1;
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end
        end
    end

    // Line buffers read-before-write; window column 2 is the newest (rows top..bottom).
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_lb0[w_addr] <= in_data;
            r_lb1[w_addr] <= w_lb0;
            for (int unsigned i = 0; i < 2; i++)
                r_win[i] <= r_win[i+1];
            r_win[2][0] <= w_lb1;
            r_win[2][1] <= w_lb0;
            r_win[2][2] <= in_data;
        end
    end

    always_comb begin
        w_left  = DW'(r_win[0][0]) + DW'({r_win[0][1], 1'b0}) + DW'(r_win[0][2]);
        w_right = DW'(r_win[2][0]) + DW'({r_win[2][1], 1'b0}) + DW'(r_win[2][2]);
        w_top   = DW'(r_win[0][0]) + DW'({r_win[1][0], 1'b0}) + DW'(r_win[2][0]);
        w_bot   = DW'(r_win[0][2]) + DW'({r_win[1][2], 1'b0}) + DW'(r_win[2][2]);
        w_dx    = $signed(w_left - w_right);
        w_dy    = $signed(w_top - w_bot);
        w_sum   = SW'(r_adx) + SW'(r_ady);
        w_sat   = (w_sum > SAT) ? '1 : w_sum[WORD_SIZE-1:0];
    end

`ifdef SOBEL_DIRECTION_EN
    logic r_same2;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1      <= 1'b0;
            r_sof1    <= 1'b0;
            r_eol1    <= 1'b0;
            r_bord1   <= 1'b0;
            r_v2      <= 1'b0;
            r_sof2    <= 1'b0;
            r_eol2    <= 1'b0;
            r_bord2   <= 1'b0;
            r_adx     <= '0;
            r_ady     <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_mag   <= '0;
            out_edge  <= 1'b0;
`ifdef SOBEL_DIRECTION_EN
            r_same2   <= 1'b0;
            out_dir   <= 2'd0;
`endif
        end else begin
            r_v1 <= w_acc;
            if (w_acc) begin
                r_sof1  <= in_sof;
                r_eol1  <= in_eol;
                r_bord1 <= (w_row < 16'd2) || (w_col < COL_W'(2));
            end
            r_v2 <= r_v1;
            if (r_v1) begin
                r_sof2  <= r_sof1;
                r_eol2  <= r_eol1;
                r_bord2 <= r_bord1;
                r_adx   <= w_dx[DW-1] ? $unsigned(-w_dx) : $unsigned(w_dx);
                r_ady   <= w_dy[DW-1] ? $unsigned(-w_dy) : $unsigned(w_dy);
`ifdef SOBEL_DIRECTION_EN
                r_same2 <= (w_dx[DW-1] == w_dy[DW-1]);
`endif
            end
            out_valid <= r_v2;
            if (r_v2) begin
                out_sof  <= r_sof2;
                out_eol  <= r_eol2;
                out_mag  <= r_bord2 ? '0 : w_sat;
                out_edge <= !r_bord2 && (w_sat > threshold);
`ifdef SOBEL_DIRECTION_EN
                if (r_bord2 || ({1'b0, r_adx} >= {r_ady, 1'b0}))
                    out_dir <= 2'd0;
                else if ({1'b0, r_ady} >= {r_adx, 1'b0})
                    out_dir <= 2'd1;
                else if (r_same2)
                    out_dir <= 2'd2;
                else
                    out_dir <= 2'd3;
`endif
            end
        end
    end

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Scoreboard bench for sobel_stream_filter: a per-column pixel history model predicts each output beat.
module tb_sobel_stream_filter;

    localparam int WS   = 8;
    localparam int MAXW = 16;
    localparam int CW   = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CW-1:0] frame_width = '0;
    logic [WS-1:0] threshold = '0;
    logic          in_valid = 1'b0, in_sof = 1'b0, in_eol = 1'b0;
    logic [WS-1:0] in_data = '0;
    logic          out_valid, out_sof, out_eol, out_edge, len_err, cfg_err;
    logic [WS-1:0] out_mag;
`ifdef SOBEL_DIRECTION_EN
    logic [1:0]    out_dir;
`endif

    sobel_stream_filter #(.WORD_SIZE(WS), .MAX_WIDTH(MAXW), .COL_W(CW)) dut (
        .clk(clk), .reset(reset), .frame_width(frame_width), .threshold(threshold),
        .in_valid(in_valid), .in_sof(in_sof), .in_eol(in_eol), .in_data(in_data),
        .out_valid(out_valid), .out_sof(out_sof), .out_eol(out_eol), .out_mag(out_mag),
        .out_edge(out_edge),
`ifdef SOBEL_DIRECTION_EN
        .out_dir(out_dir),
`endif
        .len_err(len_err), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int mag;
        bit edg;
        bit sof;
        bit eol;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;
    int   hist[MAXW][$];
    int   cyc = 0;
    int   n_cmp = 0, n_err = 0, n_outs = 0, n_edges = 0;
    int   thr = 0;
    bit   m_act = 0, m_len = 0, m_cfg = 0;
    int   m_row = 0, m_col = 0, m_w = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic int px(input int col, input int age);
        int n;
        n = hist[col].size();
        return hist[col][n-1-age];
    endfunction

    // age 0 = current row, 2 = two rows above; columns c-2..c
    function automatic int sobel(input int c);
        int dx, dy, s;
        dx = (px(c-2,2) + 2*px(c-2,1) + px(c-2,0)) - (px(c,2) + 2*px(c,1) + px(c,0));
        dy = (px(c-2,2) + 2*px(c-1,2) + px(c,2)) - (px(c-2,0) + 2*px(c-1,0) + px(c,0));
        s  = (dx < 0 ? -dx : dx) + (dy < 0 ? -dy : dy);
        return (s > (1 << WS) - 1) ? (1 << WS) - 1 : s;
    endfunction

    task automatic model(input bit sof, input bit eol, input int d, input int fw);
        bit acc;
        int r, c, mag;
        exp_t e;
        acc = 0; r = 0; c = 0;
        if (sof) begin
            if (fw >= 3 && fw <= MAXW) begin
                m_act = 1; m_w = fw; m_len = 0; m_cfg = 0;
                acc = 1; m_row = 0; m_col = 1;
            end else begin
                m_act = 0; m_cfg = 1;
            end
        end else if (m_act) begin
            acc = 1; r = m_row; c = m_col;
            if (eol || c == m_w - 1) begin
                if (eol != (c == m_w - 1)) m_len = 1;
                m_col = 0;
                if (m_row < 65535) m_row++;
            end else begin
                m_col++;
            end
        end
        if (acc) begin
            hist[c].push_back(d);
            if (hist[c].size() > 3) void'(hist[c].pop_front());
            mag = (r >= 2 && c >= 2) ? sobel(c) : 0;
            e.cyc = cyc + 3; e.mag = mag; e.edg = (mag > thr);
            e.sof = sof; e.eol = eol;
            q.push_back(e);
        end
    endtask

    task automatic beat(input bit sof, input bit eol, input int d, input int fw);
        in_valid = 1; in_sof = sof; in_eol = eol; in_data = WS'(d);
        frame_width = sof ? CW'(fw) : CW'($urandom_range(0, 31));
        model(sof, eol, d, fw);
        @(posedge clk); #1;
        in_valid = 0; in_sof = 0; in_eol = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_row(input int w, input int n, input bit first, input int kind, input bit gap);
        for (int c = 0; c < n; c++) begin
            int d;
            case (kind)
                0:       d = 100;
                1:       d = (c < 4) ? 0 : 200;
                default: d = $urandom_range(0, 255);
            endcase
            beat(first && c == 0, c == n - 1, d, w);
            if (gap) idle(1);
            else if (kind == 2 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
    endtask

    task automatic send_frame(input int w, input int rows, input int kind, input bit gap);
        for (int r = 0; r < rows; r++) send_row(w, w, r == 0, kind, gap);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() > 0 && k < 20) begin @(posedge clk); #1; k++; end
        chk("drain_queue_left", q.size(), 0);
    endtask

    task automatic set_thr(input int t);
        thr = t; threshold = WS'(t);
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid) begin
            n_outs++;
            if (out_edge) n_edges++;
            if (q.size() == 0) begin
                chk("out_valid_unexpected", int'(out_valid), 0);
            end else begin
                e_mon = q.pop_front();
                chk("latency_cycle", cyc, e_mon.cyc);
                chk("out_mag", int'(out_mag), e_mon.mag);
                chk("out_edge", int'(out_edge), int'(e_mon.edg));
                chk("out_sof", int'(out_sof), int'(e_mon.sof));
                chk("out_eol", int'(out_eol), int'(e_mon.eol));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int o0, e0;
        repeat (3) @(posedge clk); #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sof", int'(out_sof), 0);
        chk("rst_out_eol", int'(out_eol), 0);
        chk("rst_out_mag", int'(out_mag), 0);
        chk("rst_out_edge", int'(out_edge), 0);
        chk("rst_len_err", int'(len_err), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
        reset = 0;
        idle(2);

        // flat frame
        set_thr(50);
        o0 = n_outs;
        send_frame(8, 4, 0, 0);
        drain();
        chk("flat_out_count", n_outs - o0, 32);

        // vertical step, contiguous then gapped
        set_thr(150);
        o0 = n_outs; e0 = n_edges;
        send_frame(8, 4, 1, 0);
        drain();
        chk("step_out_count", n_outs - o0, 32);
        chk("step_edge_count", n_edges - e0, 4);
        e0 = n_edges;
        send_frame(8, 4, 1, 1);
        drain();
        chk("gap_step_edge_count", n_edges - e0, 4);

        // short row
        set_thr(80);
        send_row(8, 8, 1, 2, 0);
        chk("len_err_ok_row", int'(len_err), int'(m_len));
        send_row(8, 6, 0, 2, 0);
        chk("len_err_set", int'(len_err), 1);
        send_row(8, 8, 0, 2, 0);
        send_row(8, 8, 0, 2, 0);
        drain();
        beat(1, 0, 7, 8);
        chk("len_err_clear", int'(len_err), 0);
        send_row(8, 7, 0, 2, 0);
        send_frame(8, 3, 2, 0);
        drain();

        // illegal widths
        o0 = n_outs;
        beat(1, 0, 10, 2);
        repeat (4) beat(0, 0, 20, 8);
        drain();
        idle(4);
        chk("cfg_err_w2", int'(cfg_err), 1);
        chk("cfg_no_output", n_outs - o0, 0);
        beat(1, 0, 10, MAXW + 1);
        chk("cfg_err_wmax1", int'(cfg_err), 1);
        o0 = n_outs;
        beat(1, 0, 30, 8);
        chk("cfg_err_clear", int'(cfg_err), 0);
        send_row(8, 7, 0, 2, 0);
        send_frame(8, 2, 2, 0);
        drain();
        chk("cfg_resume_count", n_outs - o0, 24);

        // random frames including width extremes
        for (int f = 0; f < 8; f++) begin
            int w;
            w = (f == 0) ? MAXW : (f == 1) ? 3 : $urandom_range(3, MAXW);
            set_thr($urandom_range(0, 255));
            send_frame(w, $urandom_range(3, 5), 2, 0);
            drain();
        end

        // reset mid-frame
        send_row(8, 8, 1, 2, 0);
        send_row(8, 2, 0, 2, 0);
        reset = 1;
        q.delete();
        m_act = 0; m_row = 0; m_col = 0; m_len = 0; m_cfg = 0;
        #1;
        chk("midreset_out_valid", int'(out_valid), 0);
        chk("midreset_len_err", int'(len_err), 0);
        idle(2);
        reset = 0;
        o0 = n_outs;
        repeat (6) beat(0, 0, 55, 8);
        idle(5);
        chk("post_reset_no_output", n_outs - o0, 0);

        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
